fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the SoC's basic buffer FIFO.
//  Adds FWFT/standard read mode, occupancy output, programmable almost-full/empty,
//  synchronous flush and sticky overflow/underflow flags.
//  Sits between PicoRV32 bus peripherals (UART, SPI, DMA) and their datapaths.
// PARAMETERS
//  DATA_WIDTH  32             data word width, >=1
//  DEPTH       16             entries; power of two, >=2
//  FWFT        0              0: registered read, 1 cycle latency; 1: first-word-fall-through
//  AF_THRESH   DEPTH-2        almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   1              almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  PTR_WIDTH   $clog2(DEPTH)  derived; not to be overridden
// PORTS
//  clk           in   1              clock, rising edge
//  resetn        in   1              synchronous reset, active-low
//  flush         in   1              sync clear of contents, pointers, count
//  wr_en         in   1              write request
//  data_in       in   DATA_WIDTH     write data
//  full          out  1              count == DEPTH
//  almost_full   out  1              count >= AF_THRESH
//  rd_en         in   1              read request (FWFT=1: pop/acknowledge of data_out)
//  data_out      out  DATA_WIDTH     read data
//  rd_valid      out  1              FWFT=0: data_out updated this cycle; FWFT=1: == !empty
//  empty         out  1              count == 0
//  almost_empty  out  1              count <= AE_THRESH
//  count         out  PTR_WIDTH+1    current occupancy, 0..DEPTH
//  overflow      out  1              sticky: write rejected
//  underflow     out  1              sticky: read on empty
//  err_clr       in   1              clears overflow/underflow
// BEHAVIOUR
//  Reset (resetn=0 at posedge): wr_ptr, rd_ptr, count=0; data_out=0; rd_valid=0;
//   overflow=underflow=0; empty=1, almost_empty=1, full=0, almost_full=0. mem not cleared.
//  rd_acc = rd_en & !empty;  wr_acc = wr_en & (!full | rd_acc)   (write-through when full
//   and reading same cycle; no combinational loop since rd_acc depends only on count).
//  rd_en & wr_en on empty: read rejected (underflow set), write accepted.
//  count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither.
//  Pointers wrap modulo DEPTH by natural overflow of PTR_WIDTH bits.
//  Flags are combinational from the registered count only (glitch-free, no input paths).
//  FWFT=0: on rd_acc, data_out <= mem[rd_ptr] at next edge, rd_valid=1 for that one cycle;
//   otherwise data_out holds, rd_valid=0. Latency rd_en -> data 1 cycle.
//   Write-to-read: word written at edge N readable by rd_en sampled at edge N+1.
//  FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty (0 when empty);
//   first word visible the cycle after its write; rd_en pops it.
//  flush=1: pointers, count=0 next edge; wr/rd in same cycle ignored; data_out=0,
//   rd_valid=0; sticky flags unaffected. resetn has priority over flush.
//  overflow  <= 1 when wr_en & !wr_acc; underflow <= 1 when rd_en & empty.
//  err_clr clears both; a new error event in the same cycle wins (flag stays 1).
//  Reset mid-operation: all state returns to reset values at that edge; in-flight data lost.
// STRUCTURE
//  fifo_pkg: fifo_status_t packed struct {full, almost_full, empty, almost_empty,
//   overflow, underflow} for CSR mapping; localparam FIFO_MODE_STD=0, FIFO_MODE_FWFT=1.
//  Sub-module fifo_mem_dp: DEPTH x DATA_WIDTH simple dual-port RAM, sync write,
//   async read; top wraps output register for FWFT=0.
//  Elaboration-time assertions: DEPTH power of two, threshold ranges.
// TESTING  (DATA_WIDTH=32, DEPTH=8, AF_THRESH=6, AE_THRESH=1; both FWFT values)
//  1 Fill 8 words 0xA0..0xA7 -> full=1 after 8th, almost_full from count=6, count=8;
//    9th wr_en -> not stored, overflow=1 next cycle, count stays 8.
//  2 Drain 8 (FWFT=0) -> data_out 0xA0..0xA7 each 1 cycle after rd_en, rd_valid pulses;
//    extra rd_en -> underflow=1, data_out holds 0xA7; err_clr -> both flags 0.
//  3 Full + simultaneous wr_en/rd_en with 0xB0 -> count stays 8, no overflow, 0xB0 read last.
//  4 Empty + simultaneous wr_en/rd_en -> count=1, underflow=1; FWFT=1 data_out=word next cycle.
//  5 Write 20 words interleaved with reads, count<=3 -> pointer wrap, order preserved 1:1.
//  6 count=5, assert flush with wr_en -> count=0, empty=1 next cycle; resetn=0 mid-burst
//    -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the synchronous FIFO family.
// The status struct gives the CSR block a single packed view of the FIFO flags.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_WIDTH simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard/FWFT read, occupancy, programmable
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_LVL   = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL   = (PTR_WIDTH+1)'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
  end
  if ((PTR_WIDTH != $clog2(DEPTH)) || (DATA_WIDTH < 1)) begin : g_bad_width
    $error("fifo_sync_param: PTR_WIDTH is derived, DATA_WIDTH must be >= 1");
  end
  if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]    cnt;
  logic                  ovf_q, unf_q;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t          st;

  // Flags come from the registered count only, so no input reaches them combinationally.
  assign st.empty        = (cnt == '0);
  assign st.full         = (cnt == FULL_LVL);
  assign st.almost_full  = (cnt >= AF_LVL);
  assign st.almost_empty = (cnt <= AE_LVL);
  assign st.overflow     = ovf_q;
  assign st.underflow    = unf_q;

  assign {full, almost_full, empty, almost_empty, overflow, underflow} = st;
  assign count = cnt;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_acc = rd_en & ~st.empty;
  assign wr_acc = wr_en & (~st.full | rd_acc);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      cnt <= cnt + 1'b1;
      else if (rd_acc && !wr_acc) cnt <= cnt - 1'b1;
    end
  end

  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~err_clr) | (wr_en & ~wr_acc);
      unf_q <= (unf_q & ~err_clr) | (rd_en & st.empty);
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (PTR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc & resetn & ~flush),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out = st.empty ? '0 : mem_rdata;
    assign rd_valid = ~st.empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rv_q;

    always_ff @(posedge clk) begin
      if (!resetn || flush) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) dout_q <= mem_rdata;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rv_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and checks
// both against a queue-based model, plus directed scenarios with literal expectations.
module tb_fifo_sync_param;
  localparam int DW = 32, DEPTH = 8, AF = 6, AE = 1;

  logic          clk = 1'b0;
  logic          resetn, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] data_in;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_rv, f_rv, s_full, f_full, s_af, f_af, s_empty, f_empty;
  logic          s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [3:0]    s_count, f_count;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf, m_rv;
  logic [DW-1:0] m_dout;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .resetn(resetn), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .full(s_full), .almost_full(s_af), .rd_en(rd_en), .data_out(s_dout), .rd_valid(s_rv),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_unf), .err_clr(err_clr));

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .resetn(resetn), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en), .data_out(f_dout), .rd_valid(f_rv),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .err_clr(err_clr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic we, input logic [31:0] d, input logic re,
                      input logic fl, input logic ec, input logic rs);
    wr_en = we; data_in = d; rd_en = re; flush = fl; err_clr = ec; resetn = rs;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a queue plus the sticky flags, advanced on each rising edge.
  initial forever begin
    bit emp, ful, racc, wacc;
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_rv = 1'b0;
    end else begin
      emp  = (mq.size() == 0);
      ful  = (mq.size() == DEPTH);
      racc = rd_en && !emp;
      wacc = wr_en && (!ful || racc);
      m_ovf = (m_ovf && !err_clr) || (wr_en && !wacc);
      m_unf = (m_unf && !err_clr) || (rd_en && emp);
      if (flush) begin
        mq.delete();
        m_dout = '0; m_rv = 1'b0;
      end else begin
        m_rv = racc;
        if (racc) m_dout = mq.pop_front();
        if (wacc) mq.push_back(data_in);
      end
    end
  end

  initial forever begin
    int n;
    @(negedge clk);
    if (chk_en) begin
      n = mq.size();
      chk("count_std", 32'(s_count), n);
      chk("count_fwft", 32'(f_count), n);
      chk("empty_std", 32'(s_empty), 32'(n == 0));
      chk("empty_fwft", 32'(f_empty), 32'(n == 0));
      chk("full_std", 32'(s_full), 32'(n == DEPTH));
      chk("full_fwft", 32'(f_full), 32'(n == DEPTH));
      chk("af_std", 32'(s_af), 32'(n >= AF));
      chk("af_fwft", 32'(f_af), 32'(n >= AF));
      chk("ae_std", 32'(s_ae), 32'(n <= AE));
      chk("ae_fwft", 32'(f_ae), 32'(n <= AE));
      chk("ovf_std", 32'(s_ovf), 32'(m_ovf));
      chk("ovf_fwft", 32'(f_ovf), 32'(m_ovf));
      chk("unf_std", 32'(s_unf), 32'(m_unf));
      chk("unf_fwft", 32'(f_unf), 32'(m_unf));
      chk("dout_std", s_dout, m_dout);
      chk("rv_std", 32'(s_rv), 32'(m_rv));
      chk("dout_fwft", f_dout, (n != 0) ? mq[0] : 32'h0);
      chk("rv_fwft", 32'(f_rv), 32'(n != 0));
    end
  end

  initial begin
    int wrote, nrd, guard;
    logic w, r;
    resetn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_count", 32'(s_count), 0);
    chk("rst_flags", {26'd0, s_full, s_af, s_empty, s_ae, s_ovf, s_unf}, 32'b001100);
    chk("rst_dout", s_dout, 0);
    chk("rst_rv", 32'(s_rv | f_rv), 0);

    // fill to full, then one rejected write
    for (int i = 0; i < 8; i++) begin
      step(1, 32'hA0 + i, 0, 0, 0, 1);
      chk("fill_af", 32'(s_af), 32'(i >= 5));
    end
    chk("fill_full", 32'(s_full), 1);
    chk("fill_count", 32'(s_count), 8);
    chk("fwft_head", f_dout, 32'hA0);
    step(1, 32'hFF, 0, 0, 0, 1);
    chk("ovf_set", 32'(s_ovf), 1);
    chk("ovf_count", 32'(s_count), 8);

    // drain in order, then read on empty
    for (int i = 0; i < 8; i++) begin
      chk("fwft_pop", f_dout, 32'hA0 + i);
      step(0, 0, 1, 0, 0, 1);
      chk("drain_data", s_dout, 32'hA0 + i);
      chk("drain_rv", 32'(s_rv), 1);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("rv_pulse", 32'(s_rv), 0);
    step(0, 0, 1, 0, 0, 1);
    chk("unf_set", 32'(s_unf), 1);
    chk("unf_hold", s_dout, 32'hA7);
    step(0, 0, 0, 0, 1, 1);
    chk("err_clr", {30'd0, s_ovf, s_unf}, 0);

    // write-through while full
    for (int i = 0; i < 8; i++) step(1, 32'hA0 + i, 0, 0, 0, 1);
    step(1, 32'hB0, 1, 0, 0, 1);
    chk("wt_count", 32'(s_count), 8);
    chk("wt_noovf", 32'(s_ovf), 0);
    chk("wt_data", s_dout, 32'hA0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 1);
    chk("wt_last", s_dout, 32'hB0);

    // simultaneous read/write on empty
    step(1, 32'hC5, 1, 0, 0, 1);
    chk("ew_count", 32'(s_count), 1);
    chk("ew_unf", 32'(s_unf), 1);
    chk("ew_fwft", f_dout, 32'hC5);
    step(0, 0, 1, 0, 1, 1);
    chk("ew_read", s_dout, 32'hC5);

    // interleaved traffic across pointer wrap, occupancy kept at or below 3
    wrote = 0; nrd = 0; guard = 0;
    while ((wrote < 20 || mq.size() > 0) && guard < 400) begin
      w = (wrote < 20) && (mq.size() < 3) && ($urandom_range(0, 1) == 1);
      r = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      step(w, 32'hD00 + wrote, r, 0, 0, 1);
      if (w) wrote++;
      if (s_rv) begin
        chk("wrap_order", s_dout, 32'hD00 + nrd);
        nrd++;
      end
      guard++;
    end
    chk("wrap_reads", nrd, 20);

    // flush keeps sticky flags, reset clears everything
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 32'hE0 + i, 0, 0, 0, 1);
    chk("fl_pre", 32'(s_count), 5);
    step(1, 32'hEE, 0, 1, 0, 1);
    chk("fl_count", 32'(s_count), 0);
    chk("fl_empty", 32'(s_empty), 1);
    chk("fl_unf", 32'(s_unf), 1);
    for (int i = 0; i < 3; i++) step(1, 32'hF0 + i, i == 2, 0, 0, 1);
    step(1, 32'hF9, 1, 0, 0, 0);
    chk("mr_count", 32'(s_count), 0);
    chk("mr_flags", {26'd0, s_full, s_af, s_empty, s_ae, s_ovf, s_unf}, 32'b001100);
    chk("mr_dout", s_dout, 0);
    chk("mr_rv", 32'(s_rv), 0);

    // randomized traffic, write-heavy then read-heavy
    for (int c = 0; c < 3000; c++) begin
      int wb;
      wb = (c < 1500) ? 65 : 35;
      step($urandom_range(0, 99) < wb, $urandom, $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) >= 1);
    end
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
